// File: rtl/upd1771c_pkg.sv
// upd1771c_pkg
//   Shared constants and types for the simplified uPD1771C sound core:
//   host command codes, the packet-state enum, default timing parameters
//   and the noise LFSR seed (used only when UPD1771C_NOISE_EN is defined).
package upd1771c_pkg;

  localparam logic [7:0] CMD_SILENCE = 8'h00;
  localparam logic [7:0] CMD_NOISE   = 8'h01;
  localparam logic [7:0] CMD_TONE    = 8'h02;

  localparam int DEF_CP1_DIV   = 8;
  localparam int DEF_READY_DLY = 16;

  localparam logic [14:0] LFSR_SEED = 15'h7FFF;

  typedef enum logic [2:0] {
    IDLE,
    TONE1,
    TONE2,
    TONE3,
    NOISE1
  } pkt_state_t;

endpackage

// File: rtl/upd1771c_tone.sv
// upd1771c_tone
//   Tone generator: 8-bit period counter and 5-bit phase advanced on cp1p,
//   duty-cycle compare against the timbre, and the signed amplitude register.
//   Optional noise mode (macro UPD1771C_NOISE_EN) replaces the duty compare
//   with bit 0 of a 15-bit LFSR that steps on every phase advance.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clr            synchronous clear (mode pins out of normal operation)
//   en             clock enable
//   cp1p           phase strobe
//   commit         load timbre/offset/period/volume, phase := offset
//   commit_noise   (noise build only) load volume and enter noise mode
//   silence        volume := 0
//   timbre, offset, period, volume   staged tone registers
//   aud            signed audio sample
module upd1771c_tone
  import upd1771c_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       cp1p,
  input  logic       commit,
`ifdef UPD1771C_NOISE_EN
  input  logic       commit_noise,
`endif
  input  logic       silence,
  input  logic [2:0] timbre,
  input  logic [4:0] offset,
  input  logic [7:0] period,
  input  logic [4:0] volume,
  output logic [7:0] aud
);

  logic [7:0]        cnt_r;
  logic [4:0]        phase_r;
  logic [2:0]        timbre_r;
  logic [7:0]        period_r;
  logic [4:0]        vol_r;
  logic signed [7:0] aud_p0;
  logic [8:0]        period_len;
  logic              wrap;
  logic [5:0]        thresh;
  logic              high;
`ifdef UPD1771C_NOISE_EN
  logic              noise_r;
  logic [14:0]       lfsr_r;
`endif

  // +/- volume*4; at most 124 in magnitude, so it never overflows 8 bits.
  function automatic logic signed [7:0] amp(input logic hi, input logic [4:0] v);
    logic signed [7:0] mag;
    mag = signed'({1'b0, v, 2'b00});
    return hi ? mag : -mag;
  endfunction

  // A programmed period of 0 stands for 256 cp1p periods per phase step.
  assign period_len = (period_r == 8'd0) ? 9'd256 : {1'b0, period_r};
  assign wrap       = ({1'b0, cnt_r} + 9'd1) == period_len;
  assign thresh     = {1'b0, timbre_r, 2'b00} + 6'd4;

`ifdef UPD1771C_NOISE_EN
  assign high = noise_r ? lfsr_r[0] : ({1'b0, phase_r} < thresh);
`else
  assign high = {1'b0, phase_r} < thresh;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= '0;
      phase_r  <= '0;
      timbre_r <= '0;
      period_r <= '0;
      vol_r    <= '0;
      aud_p0   <= '0;
`ifdef UPD1771C_NOISE_EN
      noise_r  <= 1'b0;
      lfsr_r   <= LFSR_SEED;
`endif
    end else if (clr) begin
      cnt_r    <= '0;
      phase_r  <= '0;
      timbre_r <= '0;
      period_r <= '0;
      vol_r    <= '0;
      aud_p0   <= '0;
`ifdef UPD1771C_NOISE_EN
      noise_r  <= 1'b0;
      lfsr_r   <= LFSR_SEED;
`endif
    end else if (en) begin
      // stage p0: tone state, committed atomically by a finished packet
      if (commit) begin
        timbre_r <= timbre;
        period_r <= period;
        vol_r    <= volume;
        phase_r  <= offset;
        cnt_r    <= '0;
`ifdef UPD1771C_NOISE_EN
        noise_r  <= 1'b0;
`endif
      end
`ifdef UPD1771C_NOISE_EN
      else if (commit_noise) begin
        vol_r   <= volume;
        noise_r <= 1'b1;
        lfsr_r  <= LFSR_SEED;
        cnt_r   <= '0;
      end
`endif
      else begin
        if (silence) vol_r <= 5'd0;
        if (cp1p) begin
          if (wrap) begin
            cnt_r   <= '0;
            phase_r <= phase_r + 5'd1;
`ifdef UPD1771C_NOISE_EN
            if (noise_r) lfsr_r <= {lfsr_r[13:0], lfsr_r[14] ^ lfsr_r[13]};
`endif
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
      end
      // stage p1: amplitude register, one clock behind the tone state
      aud_p0 <= amp(high, vol_r);
    end
  end

  assign aud = aud_p0;

endmodule

// File: rtl/upd1771c_core.sv
// upd1771c_core
//   Simplified NEC uPD1771C sound core (Super Cassette Vision).
//   The host writes command packets on port A, strobed by /CS and /WR on
//   PB[7:6]; each byte is paced with the DSB handshake on PB[0].
//   Packets: 00 = silence, 02 tb pp vv = tone (timbre/offset, period, volume).
//   Optional feature macro: UPD1771C_NOISE_EN (01 vv = noise at volume vv).
// Ports:
//   CLK    system clock          RESB   asynchronous active-low reset
//   CKEN   clock enable          CH1/CH2 mode pins (1/0 for normal operation)
//   PA_I   host data             PA_O/PA_OE  tied to 0 (input-only port)
//   PB_I   bit7 /CS, bit6 /WR    PB_O   bit0 DSB     PB_OE  8'h01
//   AUD_O  signed audio sample
module upd1771c_core
  import upd1771c_pkg::*;
#(
  parameter int CP1_DIV   = DEF_CP1_DIV,
  parameter int READY_DLY = DEF_READY_DLY
) (
  input  logic       CLK,
  input  logic       RESB,
  input  logic       CKEN,
  input  logic       CH1,
  input  logic       CH2,
  input  logic [7:0] PA_I,
  output logic [7:0] PA_O,
  output logic [7:0] PA_OE,
  input  logic [7:0] PB_I,
  output logic [7:0] PB_O,
  output logic [7:0] PB_OE,
  output logic [7:0] AUD_O
);

  localparam logic [15:0] DIV_LAST = 16'(CP1_DIV - 1);
  localparam logic [15:0] RDY_INIT = 16'(READY_DLY);

  pkt_state_t  state, state_nx, cur;
  logic [15:0] div_cnt;
  logic [15:0] rdy_cnt;
  logic        hold, wr_n, wr_q, wr_fall, cp1p, consume, resync, more;
  logic [7:0]  byte_r;
  logic        byte_vld;
  logic        dsb, rdy_wait;
  logic [2:0]  timbre_s;
  logic [4:0]  offset_s;
  logic [7:0]  period_s;
  logic        ld_t1, ld_t2, commit_tone, silence;
`ifdef UPD1771C_NOISE_EN
  logic        commit_noise;
`endif
  logic        unused_pb;

  assign hold      = ~CH1 | CH2;
  assign wr_n      = PB_I[7] | PB_I[6];
  assign unused_pb = ^PB_I[5:0];

  assign cp1p    = CKEN & (div_cnt == DIV_LAST);
  assign wr_fall = CKEN & wr_q & ~wr_n;
  assign consume = cp1p & byte_vld;
  // A byte arriving while a packet is waiting out the ready delay means the
  // host lost sync; treat it as a fresh command.
  assign resync  = (state != IDLE) && !dsb;

  always_comb begin
    state_nx    = state;
    cur         = state;
    ld_t1       = 1'b0;
    ld_t2       = 1'b0;
    commit_tone = 1'b0;
    silence     = 1'b0;
`ifdef UPD1771C_NOISE_EN
    commit_noise = 1'b0;
`endif
    if (consume) begin
      if (resync) cur = IDLE;
      state_nx = IDLE;
      unique case (cur)
        IDLE: begin
          if (byte_r == CMD_TONE) state_nx = TONE1;
          else if (byte_r == CMD_SILENCE) silence = 1'b1;
`ifdef UPD1771C_NOISE_EN
          else if (byte_r == CMD_NOISE) state_nx = NOISE1;
`endif
        end
        TONE1: begin
          ld_t1    = 1'b1;
          state_nx = TONE2;
        end
        TONE2: begin
          ld_t2    = 1'b1;
          state_nx = TONE3;
        end
        TONE3: commit_tone = 1'b1;
        NOISE1: begin
          state_nx = IDLE;
`ifdef UPD1771C_NOISE_EN
          commit_noise = 1'b1;
`endif
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign more = (state_nx != IDLE);

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state    <= IDLE;
      div_cnt  <= '0;
      wr_q     <= 1'b1;
      byte_r   <= '0;
      byte_vld <= 1'b0;
      dsb      <= 1'b0;
      rdy_wait <= 1'b0;
      rdy_cnt  <= '0;
      timbre_s <= '0;
      offset_s <= '0;
      period_s <= '0;
    end else if (hold) begin
      state    <= IDLE;
      div_cnt  <= '0;
      wr_q     <= 1'b1;
      byte_r   <= '0;
      byte_vld <= 1'b0;
      dsb      <= 1'b0;
      rdy_wait <= 1'b0;
      rdy_cnt  <= '0;
      timbre_s <= '0;
      offset_s <= '0;
      period_s <= '0;
    end else if (CKEN) begin
      // stage p0: strobe divider, write-edge capture, packet state
      state   <= state_nx;
      div_cnt <= cp1p ? '0 : div_cnt + 16'd1;
      wr_q    <= wr_n;
      // A new edge wins over consumption: a write landing on cp1p is kept
      // for the following cp1p, and a second write overwrites the first.
      if (wr_fall) begin
        byte_r   <= PA_I;
        byte_vld <= 1'b1;
      end else if (consume) begin
        byte_vld <= 1'b0;
      end
      if (ld_t1) begin
        timbre_s <= byte_r[7:5];
        offset_s <= byte_r[4:0];
      end
      if (ld_t2) period_s <= byte_r;
      // DSB drops on consumption and, if more bytes are due, rises after
      // READY_DLY further cp1p strobes.
      if (consume) begin
        dsb      <= 1'b0;
        rdy_wait <= more;
        rdy_cnt  <= RDY_INIT;
      end else if (cp1p && rdy_wait) begin
        if (rdy_cnt <= 16'd1) begin
          dsb      <= 1'b1;
          rdy_wait <= 1'b0;
        end else begin
          rdy_cnt <= rdy_cnt - 16'd1;
        end
      end
    end
  end

  upd1771c_tone u_tone (
    .clk          (CLK),
    .rst_n        (RESB),
    .clr          (hold),
    .en           (CKEN),
    .cp1p         (cp1p),
    .commit       (commit_tone),
`ifdef UPD1771C_NOISE_EN
    .commit_noise (commit_noise),
`endif
    .silence      (silence),
    .timbre       (timbre_s),
    .offset       (offset_s),
    .period       (period_s),
    .volume       (byte_r[4:0]),
    .aud          (AUD_O)
  );

  assign PA_O  = 8'h00;
  assign PA_OE = 8'h00;
  assign PB_O  = {7'b0, dsb};
  assign PB_OE = 8'h01;

endmodule

// File: tb/tb_upd1771c_core.sv
// tb_upd1771c_core
//   Scoreboard bench for upd1771c_core: every packet pushes the AUD_O
//   transitions it should cause (value and clock gap from the previous
//   transition); a monitor pops and compares on each AUD_O change.
module tb_upd1771c_core;

  logic              CLK  = 1'b0;
  logic              RESB = 1'b1;
  logic              CKEN = 1'b1;
  logic              CH1  = 1'b1;
  logic              CH2  = 1'b0;
  logic [7:0]        pa   = 8'h00;
  logic [7:0]        pb   = 8'hFF;
  logic [7:0]        pa_o, pa_oe, pb_o, pb_oe;
  logic signed [7:0] aud;
  logic              dsb;

  typedef struct {
    int val;
    int gap;
  } ev_t;

  ev_t               exp_q[$];
  ev_t               mon_e;
  int                n_chk = 0;
  int                n_err = 0;
  int                cyc = 0;
  int                last_chg = 0;
  int                last_rise = 0;
  logic signed [7:0] aud_prev = 8'sd0;

  upd1771c_core dut (
    .CLK   (CLK),
    .RESB  (RESB),
    .CKEN  (CKEN),
    .CH1   (CH1),
    .CH2   (CH2),
    .PA_I  (pa),
    .PA_O  (pa_o),
    .PA_OE (pa_oe),
    .PB_I  (pb),
    .PB_O  (pb_o),
    .PB_OE (pb_oe),
    .AUD_O (aud)
  );

  assign dsb = pb_o[0];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string tag, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push(input int v, input int g);
    ev_t e;
    e.val = v;
    e.gap = g;
    exp_q.push_back(e);
  endtask

  // Monitor: each AUD_O change must match the next scoreboard entry.
  always @(negedge CLK) begin
    if (RESB && aud !== aud_prev) begin
      if (exp_q.size() == 0) begin
        check("aud_unexpected", aud, aud_prev);
      end else begin
        mon_e = exp_q.pop_front();
        check("aud_val", aud, mon_e.val);
        if (mon_e.gap >= 0) check("aud_gap", cyc - last_chg, mon_e.gap);
      end
      last_chg = cyc;
      aud_prev = aud;
    end
  end

  // Write strobe; cap is the clock edge that samples /WR low.
  task automatic wr_byte(input logic [7:0] b, output int cap);
    @(posedge CLK);
    #1;
    pa  = b;
    pb  = 8'h3F;
    cap = cyc + 1;
    @(posedge CLK);
    #1;
    pb = 8'hFF;
  endtask

  // hs: wait for DSB=1 first (previous byte's rise is then the timing ref).
  // more: DSB must rise again later; otherwise it must stay low.
  task automatic put(input logic [7:0] b, input bit hs, input bit more);
    int cap, n, rise;
    if (hs) begin
      n = 0;
      while (dsb !== 1'b1 && n < 300) begin
        @(negedge CLK);
        n++;
      end
      check("dsb_ready", dsb, 1);
    end
    wr_byte(b, cap);
    repeat (9) @(negedge CLK);
    check("dsb_drop", dsb, 0);
    if (more) begin
      n = 0;
      while (dsb !== 1'b1 && n < 300) begin
        @(negedge CLK);
        n++;
      end
      rise = cyc;
      if (hs) check("dsb_gap", rise - last_rise, 136);
      else check("dsb_win", int'((rise - cap >= 129) && (rise - cap <= 136)), 1);
      last_rise = rise;
    end else begin
      repeat (200) @(negedge CLK);
      check("dsb_stay0", dsb, 0);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("sb_drain", exp_q.size(), 0);
  endtask

  initial begin
    int cap;
    #2 RESB = 1'b0;
    #2000;
    check("rst_pb_o", pb_o, 0);
    check("rst_pb_oe", pb_oe, 8'h01);
    check("rst_pa_oe", pa_oe, 0);
    check("rst_pa_o", pa_o, 0);
    check("rst_aud", aud, 0);
    @(negedge CLK);
    RESB = 1'b1;
    repeat (5) @(negedge CLK);

    // Tone: timbre 4 (20/32 high), period 53, volume 21 -> +/-84.
    put(8'h02, 1'b0, 1'b1);
    put(8'h80, 1'b1, 1'b1);
    put(8'h35, 1'b1, 1'b1);
    push(84, -1);
    push(-84, 8480);
    push(84, 5088);
    push(-84, 8480);
    put(8'h15, 1'b1, 1'b0);
    drain(24000);

    // Retune in the low half: restarts high at phase 0, period 79.
    put(8'h02, 1'b0, 1'b1);
    put(8'h80, 1'b1, 1'b1);
    put(8'h4F, 1'b1, 1'b1);
    push(84, -1);
    push(-84, 12640);
    push(84, 7584);
    put(8'h15, 1'b1, 1'b0);
    drain(21000);

    // Silence.
    push(0, -1);
    put(8'h00, 1'b0, 1'b0);
    drain(10);
    check("sil_aud", aud, 0);

    // Resync: second 02 during the ready delay restarts the packet.
    wr_byte(8'h02, cap);
    repeat (40) @(negedge CLK);
    check("resync_dsb_low", dsb, 0);
    put(8'h02, 1'b0, 1'b1);
    put(8'h80, 1'b1, 1'b1);
    put(8'h35, 1'b1, 1'b1);
    push(84, -1);
    push(-84, 8480);
    push(84, 5088);
    put(8'h15, 1'b1, 1'b0);
    drain(15000);

    // Mode pin CH2=1 mid-tone forces reset values; no sound after release.
    push(0, -1);
    @(negedge CLK);
    CH2 = 1'b1;
    repeat (3) @(negedge CLK);
    check("hold_pb_o", pb_o, 0);
    check("hold_pb_oe", pb_oe, 8'h01);
    check("hold_aud", aud, 0);
    drain(5);
    CH2 = 1'b0;
    repeat (2000) @(negedge CLK);
    check("hold_quiet", aud, 0);

    // Boundaries: period 0 = 256, volume 31 = +/-124, offset 28 starts low.
    put(8'h02, 1'b0, 1'b1);
    put(8'hDC, 1'b1, 1'b1);
    put(8'h00, 1'b1, 1'b1);
    push(-124, -1);
    push(124, 8192);
    put(8'h1F, 1'b1, 1'b0);
    drain(9000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
